// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline control unit
//
// Produces the stall vector and branch flush/redirect for the PC, IF/ID and
// ID/EX pipeline registers. It arbitrates load-use, multi-cycle EX and
// memory-wait stall requests. A three-state FSM (RUN, HOLD_EX, HOLD_MEM)
// holds a taken branch back while the pipe is frozen and sequences the
// memory-wait timeout.
//
// Optional feature macro: BITTY_STALL_CNT_EN
//   defined   : stall_cycles_o counts cycles with stalled != 0 and
//               flush_cnt_o counts redirect pulses. Both are 32-bit, wrap,
//               and are cleared only by rst.
//   undefined : both outputs are tied to zero and no counter flops exist.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   stallreq_id_i      load-use hazard from ID (level)
//   stallreq_ex_i      EX multi-cycle op busy (level)
//   mem_req_i          LSU issues a bus access this cycle
//   mem_ack_i          bus completes the access
//   ex_branch_flag_i   EX resolves a taken branch (1-cycle pulse)
//   ex_branch_addr_i   branch target, valid with ex_branch_flag_i
//   stalled[2:0]       [0] ID/EX bubble, [1] IF/ID hold, [2] PC hold
//   mem_hold_o         freeze EX/MEM and MEM/WB
//   flush_o            IF/ID clear pulse
//   redirect_o         PC load pulse, coincident with flush_o
//   redirect_addr_o    redirect target; holds the last target between pulses
//   bus_err_o          memory timeout pulse
//   stall_cycles_o     stalled-cycle counter (feature-gated)
//   flush_cnt_o        redirect pulse counter (feature-gated)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    input  logic        ex_branch_flag_i,
    input  logic [31:0] ex_branch_addr_i,
    output logic [2:0]  stalled,
    output logic        mem_hold_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic        bus_err_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD_EX  = 2'd1,
        HOLD_MEM = 2'd2
    } state_t;

    state_t            state_reg;
    logic [TO_W-1:0]   count_reg;
    logic              br_pend_reg;
    logic [31:0]       br_addr_reg;
    logic              flush_reg;
    logic              redirect_reg;
    logic [31:0]       redirect_addr_reg;
    logic              bus_err_reg;

    logic              in_run;
    logic              mem_start;
    logic              start_hold;
    logic              timeout_hit;
    logic              leave_hold;
    logic              stall_all;
    logic              redirect_next;
    logic [31:0]       redirect_target;

    always_comb begin
        in_run      = (state_reg == RUN);
        mem_start   = mem_req_i & ~mem_ack_i;
        start_hold  = in_run & (mem_start | stallreq_ex_i);
        // The request cycle counts as the first wait cycle, so the timeout
        // fires after MEM_TIMEOUT stalled cycles in total.
        timeout_hit = (state_reg == HOLD_MEM) & ~mem_ack_i
                    & (count_reg == TO_W'(MEM_TIMEOUT - 1));
        leave_hold  = ((state_reg == HOLD_EX) & ~mem_start & ~stallreq_ex_i)
                    | ((state_reg == HOLD_MEM) & (mem_ack_i | timeout_hit));

        // A fresh branch in the releasing cycle is newer than the pending one.
        redirect_target = ex_branch_flag_i ? ex_branch_addr_i : br_addr_reg;
        redirect_next   = (in_run & ex_branch_flag_i & ~start_hold)
                        | (leave_hold & (ex_branch_flag_i | br_pend_reg));

        // The load-use request is ignored while a redirect is visible: the
        // instruction in ID is on the wrong path and is being flushed.
        stall_all  = ~in_run
                   | mem_start
                   | stallreq_ex_i
                   | (stallreq_id_i & ~redirect_reg);
        mem_hold_o = (state_reg == HOLD_MEM) | (in_run & mem_start);
        stalled    = {3{stall_all}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= RUN;
            count_reg         <= '0;
            br_pend_reg       <= 1'b0;
            br_addr_reg       <= '0;
            flush_reg         <= 1'b0;
            redirect_reg      <= 1'b0;
            redirect_addr_reg <= '0;
            bus_err_reg       <= 1'b0;
        end else begin
            flush_reg    <= redirect_next;
            redirect_reg <= redirect_next;
            bus_err_reg  <= timeout_hit;
            if (redirect_next) begin
                redirect_addr_reg <= redirect_target;
            end

            if (redirect_next) begin
                br_pend_reg <= 1'b0;
            end else if (ex_branch_flag_i & (~in_run | start_hold)) begin
                br_pend_reg <= 1'b1;
                br_addr_reg <= ex_branch_addr_i;
            end

            case (state_reg)
                RUN: begin
                    if (mem_start) begin
                        state_reg <= HOLD_MEM;
                        count_reg <= TO_W'(1);
                    end else if (stallreq_ex_i) begin
                        state_reg <= HOLD_EX;
                    end
                end
                HOLD_EX: begin
                    if (mem_start) begin
                        state_reg <= HOLD_MEM;
                        count_reg <= TO_W'(1);
                    end else if (!stallreq_ex_i) begin
                        state_reg <= RUN;
                    end
                end
                HOLD_MEM: begin
                    count_reg <= count_reg + 1'b1;
                    if (leave_hold) begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign flush_o         = flush_reg;
    assign redirect_o      = redirect_reg;
    assign redirect_addr_o = redirect_addr_reg;
    assign bus_err_o       = bus_err_reg;

`ifdef BITTY_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_all) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            // Counted as the pulse is launched so the count is current
            // in the same cycle redirect_o is seen.
            if (redirect_next) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_reg;
    assign flush_cnt_o    = flush_cnt_reg;
`else
    assign stall_cycles_o = 32'h0;
    assign flush_cnt_o    = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl
//
// Directed scenarios (reset, load-use bubble, memory wait with ack, memory
// timeout, branch redirect, branch held across an EX stall, reset with a
// branch pending) followed by randomized stimulus. A behavioural model that
// tracks wait episodes and pending targets predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int MEM_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        ex_branch_flag_i;
    logic [31:0] ex_branch_addr_i;
    logic [2:0]  stalled;
    logic        mem_hold_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic        bus_err_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_cnt_o;

    pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_id_i    (stallreq_id_i),
        .stallreq_ex_i    (stallreq_ex_i),
        .mem_req_i        (mem_req_i),
        .mem_ack_i        (mem_ack_i),
        .ex_branch_flag_i (ex_branch_flag_i),
        .ex_branch_addr_i (ex_branch_addr_i),
        .stalled          (stalled),
        .mem_hold_o       (mem_hold_o),
        .flush_o          (flush_o),
        .redirect_o       (redirect_o),
        .redirect_addr_o  (redirect_addr_o),
        .bus_err_o        (bus_err_o),
        .stall_cycles_o   (stall_cycles_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Behavioural model: "waiting on memory for N cycles", "held by EX",
    // a single pending branch target, and the pulses expected this cycle.
    bit          m_mem_wait, m_ex_wait;
    int          m_waited;
    bit          m_pend;
    logic [31:0] m_pend_addr;
    bit          m_redirect, m_bus_err;
    logic [31:0] m_addr;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    // Sampled values from the latest step, for scenario-level checks.
    logic [2:0]  s_stalled;
    logic        s_redirect, s_bus_err;
    logic [31:0] s_addr;

    task automatic model_reset();
        m_mem_wait = 0; m_ex_wait = 0; m_waited = 0;
        m_pend = 0; m_pend_addr = '0;
        m_redirect = 0; m_bus_err = 0; m_addr = '0;
        m_stall_cnt = '0; m_flush_cnt = '0;
    endtask

    task automatic step(input bit r, input bit id, input bit ex, input bit mreq,
                        input bit mack, input bit bf, input logic [31:0] ba);
        bit          running, mem_new, hold_new, leave, exp_mh, exp_st, n_red, n_err;
        logic [31:0] n_addr;
        rst = r; stallreq_id_i = id; stallreq_ex_i = ex; mem_req_i = mreq;
        mem_ack_i = mack; ex_branch_flag_i = bf; ex_branch_addr_i = ba;
        @(negedge clk);

        running = !m_mem_wait && !m_ex_wait;
        mem_new = mreq && !mack;
        exp_mh  = m_mem_wait || (running && mem_new);
        exp_st  = !running || mem_new || ex || (id && !m_redirect);

        s_stalled = stalled; s_redirect = redirect_o; s_bus_err = bus_err_o; s_addr = redirect_addr_o;
        check_val("stalled",    32'(stalled),    exp_st ? 32'd7 : 32'd0);
        check_val("mem_hold",   32'(mem_hold_o), 32'(exp_mh));
        check_val("redirect",   32'(redirect_o), 32'(m_redirect));
        check_val("flush",      32'(flush_o),    32'(m_redirect));
        check_val("redir_addr", redirect_addr_o, m_addr);
        check_val("bus_err",    32'(bus_err_o),  32'(m_bus_err));
`ifdef BITTY_STALL_CNT_EN
        check_val("stall_cnt",  stall_cycles_o,  m_stall_cnt);
        check_val("flush_cnt",  flush_cnt_o,     m_flush_cnt);
`else
        check_val("stall_cnt",  stall_cycles_o,  32'h0);
        check_val("flush_cnt",  flush_cnt_o,     32'h0);
`endif
        $display("cyc %0d rst=%0b id=%0b ex=%0b req=%0b ack=%0b br=%0b@%h | st=%b mh=%0b rd=%0b@%h be=%0b",
                 cyc, r, id, ex, mreq, mack, bf, ba, stalled, mem_hold_o, redirect_o,
                 redirect_addr_o, bus_err_o);

        // Advance the model by one cycle.
        n_red = 0; n_err = 0; n_addr = m_addr; leave = 0;
        if (running) begin
            hold_new = mem_new || ex;
            if (mem_new) begin
                m_mem_wait = 1; m_waited = 1;
            end else if (ex) begin
                m_ex_wait = 1;
            end
            if (bf) begin
                if (hold_new) begin
                    m_pend = 1; m_pend_addr = ba;
                end else begin
                    n_red = 1; n_addr = ba;
                end
            end
        end else begin
            if (m_mem_wait) begin
                m_waited++;
                if (mack) leave = 1;
                else if (m_waited == MEM_TIMEOUT) begin
                    leave = 1; n_err = 1;
                end
            end else if (mem_new) begin
                m_ex_wait = 0; m_mem_wait = 1; m_waited = 1;
            end else if (!ex) begin
                leave = 1;
            end
            if (leave) begin
                m_mem_wait = 0; m_ex_wait = 0;
                if (bf || m_pend) begin
                    n_red = 1; n_addr = bf ? ba : m_pend_addr; m_pend = 0;
                end
            end else if (bf) begin
                m_pend = 1; m_pend_addr = ba;
            end
        end
        if (exp_st) m_stall_cnt = m_stall_cnt + 32'd1;
        if (n_red)  m_flush_cnt = m_flush_cnt + 32'd1;
        m_redirect = n_red; m_bus_err = n_err; m_addr = n_addr;
        if (r) model_reset();

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int nstall;
        bit seen_err, seen_red;
        rst = 1'b1; stallreq_id_i = 0; stallreq_ex_i = 0; mem_req_i = 0;
        mem_ack_i = 0; ex_branch_flag_i = 0; ex_branch_addr_i = '0;

        // 1: reset for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_stalled",  32'(stalled),    32'd0);
        check_val("rst_mem_hold", 32'(mem_hold_o), 32'd0);
        check_val("rst_pulses",   32'({flush_o, redirect_o, bus_err_o}), 32'd0);
        check_val("rst_addr",     redirect_addr_o, 32'd0);
        check_val("rst_cnts",     stall_cycles_o | flush_cnt_o, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 2: single load-use bubble
        step(0, 1, 0, 0, 0, 0, 32'h0);
        check_val("lu_bubble", 32'(s_stalled), 32'd7);
        step(0, 0, 0, 0, 0, 0, 32'h0);
        check_val("lu_after",  32'(s_stalled), 32'd0);

        // 3: memory access acknowledged in its fourth cycle
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, (i == 3), 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 32'h0);
        check_val("mem_ack_nerr", 32'(s_bus_err), 32'd0);
        check_val("mem_ack_run",  32'(s_stalled), 32'd0);

        // 4: memory timeout
        nstall = 0; seen_err = 0;
        for (int i = 0; i < MEM_TIMEOUT + 3; i++) begin
            step(0, 0, 0, (i < MEM_TIMEOUT), 0, 0, 32'h0);
            if (s_stalled == 3'b111) nstall++;
            if (s_bus_err) begin
                seen_err = 1;
                check_val("to_err_when", 32'(i), 32'(MEM_TIMEOUT));
            end
        end
        check_val("to_nstall", 32'(nstall), 32'(MEM_TIMEOUT));
        check_val("to_seen",   32'(seen_err), 32'd1);

        // 5: branch in RUN
        step(0, 0, 0, 0, 0, 1, 32'h0000_0100);
        step(0, 0, 0, 0, 0, 0, 32'h0);
        check_val("br_redirect", 32'(s_redirect), 32'd1);
        check_val("br_addr",     s_addr, 32'h0000_0100);
        idle(1);

        // 6: branch during a three-cycle EX stall
        seen_red = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, (i < 3), 0, 0, (i == 1), 32'h0000_0200);
            if (s_redirect) seen_red = 1;
        end
        check_val("hold_no_red", 32'(seen_red), 32'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0);
        check_val("hold_red",      32'(s_redirect), 32'd1);
        check_val("hold_red_addr", s_addr, 32'h0000_0200);

        // 7: reset while a branch is pending discards it
        step(0, 0, 1, 0, 0, 1, 32'h0000_0300);
        step(1, 0, 0, 0, 0, 0, 32'h0);
        seen_red = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 32'h0);
            if (s_redirect) seen_red = 1;
        end
        check_val("rst_drop_pend", 32'(seen_red), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 10),
                 $urandom & 32'hFFFF_FFFC);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
